// File: rtl/product_accumulator.sv
// product_accumulator: sums N_TERMS consecutive unsigned products taken over a
// valid/ready input and presents the frame sum on a held valid/ready output.
// Optional feature macro: PRODUCT_ACCUMULATOR_SAT_EN
//   defined   -> adds saturate to all-ones for the rest of the frame, ovf reports it
//   undefined -> adds wrap modulo 2^ACC_W, ovf tied low
//
// state | meaning
// ------+-----------------------------------------------------------------
// ACCUM | accepting products, in_ready=1, building the current frame sum
// HOLD  | frame result on out_sum with out_valid=1, waiting for out_ready
module product_accumulator #(
  parameter int P_W     = 8,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       term_cnt,
  output logic             ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(N_TERMS - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W-1:0] out_sum_nxt;
  logic [7:0]       cnt_nxt;
  logic [ACC_W-1:0] in_ext;
  logic [ACC_W-1:0] add_res;
  logic             last_beat;

  assign in_ext    = ACC_W'(in_p);
  assign last_beat = (term_cnt == LAST_IDX);

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  logic             sat_q, sat_nxt;
  logic             ovf_q, ovf_nxt;
  logic [ACC_W:0]   sum_ext;
  logic             ovr;

  // Saturating add: once any add of the frame carries out, the frame stays pinned at all-ones.
  always_comb begin
    sum_ext = {1'b0, acc} + {1'b0, in_ext};
    ovr     = sum_ext[ACC_W] | sat_q;
    add_res = ovr ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  end

  // Frame saturation memory and result overflow flag, following the frame handshakes.
  always_comb begin
    sat_nxt = sat_q;
    ovf_nxt = ovf_q;
    if (state == ACCUM) begin
      if (clear) begin
        sat_nxt = 1'b0;
      end else if (in_valid) begin
        if (last_beat) begin
          sat_nxt = 1'b0;
          ovf_nxt = ovr;
        end else begin
          sat_nxt = ovr;
        end
      end
    end else if (out_ready) begin
      ovf_nxt = 1'b0;
    end
  end

  // Overflow tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sat_q <= sat_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  assign ovf = ovf_q;
`else
  assign add_res = acc + in_ext;
  assign ovf     = 1'b0;
`endif

  // Next-state and handshake outputs; in_ready depends only on state, so no out_ready->in_ready path.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = term_cnt;
    out_sum_nxt = out_sum;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (clear) begin
          acc_nxt = '0;
          cnt_nxt = 8'd0;
        end else if (in_valid) begin
          if (last_beat) begin
            out_sum_nxt = add_res;
            acc_nxt     = '0;
            cnt_nxt     = 8'd0;
            state_nxt   = HOLD;
          end else begin
            acc_nxt = add_res;
            cnt_nxt = term_cnt + 8'd1;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  // State, accumulator, term counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      term_cnt <= 8'd0;
      out_sum  <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      term_cnt <= cnt_nxt;
      out_sum  <= out_sum_nxt;
    end
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 combinational multiplier's 8-bit product.
- Accepts one product per valid/ready beat and sums N_TERMS consecutive products, for example one dot product of two 4-element operand vectors.
- Presents the sum on a held valid/ready output port.
- Sits between the multiplier output and any downstream result sink or register file.

Parameters:
- P_W, 8, width of incoming product (matches multiplier output p).
- N_TERMS, 4, products per accumulation frame; legal range 2..256.
- ACC_W, 16, accumulator/result width; legal range P_W..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- clear  input  1  synchronous flush of the partial frame; priority over in_valid.
- in_valid  input  1  in_p holds a valid product.
- in_ready  output  1  block accepts a product this cycle.
- in_p  input  P_W  unsigned product from multiplier.
- out_valid  output  1  out_sum holds a completed frame result.
- out_ready  input  1  sink accepts the result.
- out_sum  output  ACC_W  accumulated sum of N_TERMS products.
- term_cnt  output  8  number of products accepted in the current frame.
- ovf  output  1  sticky overflow flag for the current result (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high) forces the following, regardless of any in-flight frame:
  - state=ACCUM, acc=0, term_cnt=0, out_sum=0, out_valid=0, ovf=0.
  - in_ready=1 once rst deasserts.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- States:
  - ACCUM:
    - in_ready=1, out_valid=0.
    - On each input transfer: acc <= acc + zero-extended in_p, term_cnt++.
    - On the transfer where term_cnt==N_TERMS-1:
      - out_sum <= acc + in_p (ACC_W arithmetic), out_valid <= 1.
      - acc <= 0, term_cnt <= 0, next state HOLD.
  - HOLD:
    - in_ready=0; out_sum and ovf stable.
    - On output transfer: out_valid <= 0, ovf <= 0, next state ACCUM.
    - No combinational path from out_ready to in_ready, so there is a one-cycle bubble between frames.
- Latency: out_valid rises on the clock edge that accepts the Nth product, i.e. it is visible in the cycle after that transfer.
- Throughput: one product per cycle inside a frame. Frame period is at least N_TERMS+1 cycles when out_ready is held high.
- Arithmetic:
  - Unsigned only.
  - in_p zero-extended to ACC_W.
  - Default sizing (16 >= 8+log2(4)) cannot overflow.
- clear:
  - In ACCUM: acc <= 0, term_cnt <= 0; any in_p presented that cycle is dropped (in_ready remains 1, but the beat is discarded).
  - In HOLD: clear is ignored and the result is preserved.
- Simultaneous events:
  - in_valid without in_ready (HOLD): product is not consumed; upstream must hold it.
  - out_ready while out_valid=0: no effect.
- in_valid with in_p changing while in_ready=0 is legal; nothing is sampled.
- term_cnt reads 0 in HOLD.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SAT_EN.
- Defined:
  - Each add that carries out of ACC_W clamps acc, and therefore out_sum, to all-ones (2^ACC_W-1) for the rest of the frame.
  - ovf is set with out_valid and cleared on the output transfer.
- Undefined:
  - Adds wrap modulo 2^ACC_W.
  - ovf is tied to 0.

Test Plan:
- Reset mid-frame: feed 2 products (15, 15), assert rst -> out_valid=0, term_cnt=0, in_ready=1; a fresh frame of 1, 2, 3, 4 yields out_sum=10.
- Back-to-back with out_ready=1: frames {225, 225, 225, 225} and {0, 1, 0, 1} -> out_sum=900 then 2; one-cycle in_ready=0 bubble between frames; out_valid one cycle after the 4th beat.
- Backpressure: out_ready=0 for 5 cycles after a frame of 3, 3, 3, 3 -> out_valid and out_sum=12 held stable, in_ready=0 throughout; release -> in_ready=1 the next cycle.
- Input gaps: in_valid toggled 1/0 across products 6, 9, 12, 15 -> out_sum=42, term_cnt steps 1, 2, 3, then 0.
- clear: accept 50, 60, then clear with in_p=70 valid, then accept 1, 1, 1, 1 -> out_sum=4 (the 70 is dropped); clear asserted in HOLD leaves out_sum unchanged.
- Overflow (ACC_W=10, N_TERMS=8, eight products of 225, total 1800):
  - With PRODUCT_ACCUMULATOR_SAT_EN: out_sum=1023, ovf=1.
  - Without: out_sum=776 (1800 mod 1024), ovf=0.
